fetch_queue: RTL

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register and the decoder.
- Generates sequential fetch addresses to a variable-latency, in-order instruction memory and buffers returned words in a small FIFO.
- Presents one instruction per cycle to decode with a valid/ready handshake.
- Redirects and flushes on a taken jump from EX, discarding responses still in flight from the wrong path.

---
 rtl/fetch_queue.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Sequential instruction fetch with an in-order response FIFO and jump flush.
// Optional FETCH_BYPASS_EN: a kept response arriving into an empty queue goes straight to decode.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump_flag,
  input  logic [31:0] jump_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W    = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   resp_pc_reg;
  logic [31:0]   last_pc_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] drop_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [CW:0]   credit_sum;
  logic [31:0]   target_aligned;
  logic          accept;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          fifo_valid;
  logic          bypass_valid;
  logic          bypass_take;
  logic          push;
  logic          pop;

  assign target_aligned = jump_target & ~32'h0000_0003;
  assign credit_sum     = {1'b0, count_reg} + {1'b0, outstanding_reg};

  // Credits cover both buffered words and requests still in flight, so the FIFO never overflows.
  assign mem_req  = !reset && !jump_flag && (credit_sum < DEPTH_W);
  assign mem_addr = reset ? RESET_PC : fetch_pc_reg;
  assign accept   = mem_req && mem_ready;

  assign rsp_drop   = mem_rvalid && (drop_reg != '0);
  assign rsp_keep   = mem_rvalid && (drop_reg == '0) && !jump_flag && !reset;
  assign fifo_valid = (count_reg != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_valid = rsp_keep && !fifo_valid;
`else
  assign bypass_valid = 1'b0;
`endif

  assign id_valid    = !reset && !jump_flag && (fifo_valid || bypass_valid);
  assign pop         = fifo_valid && id_valid && id_ready;
  assign bypass_take = bypass_valid && id_ready;
  assign push        = rsp_keep && !bypass_take;

  always_comb begin
    id_inst = NOP_INST;
    id_pc   = last_pc_reg;
    if (reset) begin
      id_pc = '0;
    end else if (id_valid) begin
      if (fifo_valid) begin
        id_inst = inst_mem[rd_ptr_reg];
        id_pc   = pc_mem[rd_ptr_reg];
      end else begin
        id_inst = mem_rdata;
        id_pc   = resp_pc_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_reg] <= mem_rdata;
      pc_mem[wr_ptr_reg]   <= resp_pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else if (jump_flag) begin
      // Every request still in flight after this cycle belongs to the wrong path.
      fetch_pc_reg    <= target_aligned;
      resp_pc_reg     <= target_aligned;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      outstanding_reg <= outstanding_reg - CW'(mem_rvalid);
      drop_reg        <= outstanding_reg - CW'(mem_rvalid);
    end else begin
      if (accept) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
      if (rsp_keep) begin
        resp_pc_reg <= resp_pc_reg + 32'd4;
      end
      if (rsp_drop) begin
        drop_reg <= drop_reg - CW'(1);
      end
      outstanding_reg <= outstanding_reg + CW'(accept) - CW'(mem_rvalid);
      count_reg       <= count_reg + CW'(push) - CW'(pop);
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_pc_reg <= '0;
    end else begin
      last_pc_reg <= id_pc;
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(push && !pop && count_reg == FULL_COUNT));
  assert property (@(posedge clk) disable iff (reset) credit_sum <= DEPTH_W);

endmodule
